fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, 2-entry output FIFO, redirect flush.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int                      ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    next_PC_select,
    input  logic [ADDRESS_BITS-1:0] target_PC,
    input  logic                    out_ready,
    output logic [ADDRESS_BITS-1:0] PC,
    output logic [31:0]             instruction,
    output logic                    out_valid,
    output logic                    imem_req,
    output logic [ADDRESS_BITS-1:0] imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [31:0]             imem_rdata,
    output logic                    fetch_fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(3);
    localparam logic [ADDRESS_BITS-1:0] PC_STEP = ADDRESS_BITS'(4);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t                  r_state;
    state_t                  w_state_n;
    logic [ADDRESS_BITS-1:0] r_fetch_pc;
    logic [ADDRESS_BITS-1:0] w_fetch_pc_n;
    logic [ADDRESS_BITS-1:0] r_cap_pc;
    logic [ADDRESS_BITS-1:0] r_fifo_pc [2];
    logic [31:0]             r_fifo_ins [2];
    logic                    r_rptr;
    logic                    r_wptr;
    logic [1:0]              r_count;
    logic [ADDRESS_BITS-1:0] w_target;
    logic                    w_grant;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_trap;

    assign w_target = target_PC & ALIGN_MASK;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fault;
    assign w_trap      = next_PC_select & (|target_PC[1:0]);
    assign fetch_fault = r_fault;
`else
    assign w_trap      = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // Request is gated by reset so it stays low for the whole reset window.
    assign imem_req = reset && (r_state == S_REQ) &&
                      (r_count != 2'd2) && !next_PC_select;
    assign imem_addr = r_fetch_pc;
    assign w_grant   = imem_req && imem_gnt;

    assign out_valid   = (r_count != 2'd0);
    assign PC          = out_valid ? r_fifo_pc[r_rptr] : '0;
    assign instruction = out_valid ? r_fifo_ins[r_rptr] : NOP;
    assign w_pop       = out_valid && out_ready && !next_PC_select;

    always_comb begin
        w_state_n    = r_state;
        w_fetch_pc_n = r_fetch_pc;
        w_push       = 1'b0;
        if (next_PC_select) begin
            w_fetch_pc_n = w_target;
            if (w_trap) begin
                w_state_n = S_HALT;
            end else begin
                unique case (r_state)
                    S_WAIT:  w_state_n = imem_rvalid ? S_REQ : S_DRAIN;
                    S_DRAIN: w_state_n = imem_rvalid ? S_REQ : S_DRAIN;
                    S_HALT:  w_state_n = S_HALT;
                    default: w_state_n = S_REQ;
                endcase
            end
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (w_grant) begin
                        w_fetch_pc_n = r_fetch_pc + PC_STEP;
                        w_state_n    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        w_push    = 1'b1;
                        w_state_n = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        w_state_n = S_REQ;
                    end
                end
                default: w_state_n = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_cap_pc   <= '0;
        end else begin
            r_state    <= w_state_n;
            r_fetch_pc <= w_fetch_pc_n;
            if (w_grant && !next_PC_select) begin
                r_cap_pc <= r_fetch_pc;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fault <= 1'b0;
        end else if (w_trap) begin
            r_fault <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rptr        <= 1'b0;
            r_wptr        <= 1'b0;
            r_count       <= 2'd0;
            r_fifo_pc[0]  <= '0;
            r_fifo_pc[1]  <= '0;
            r_fifo_ins[0] <= NOP;
            r_fifo_ins[1] <= NOP;
        end else if (next_PC_select) begin
            r_rptr  <= 1'b0;
            r_wptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wptr]  <= r_cap_pc;
                r_fifo_ins[r_wptr] <= imem_rdata;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural imem of selectable latency.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        next_PC_select;
    logic [15:0] target_PC;
    logic        out_ready;
    logic [15:0] PC;
    logic [31:0] instruction;
    logic        out_valid;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;
    int lat = 1;
    int m_pend = 0;
    logic [15:0] m_addr;
    logic        m_g;
    logic [15:0] m_a;

    fetch_unit #(.ADDRESS_BITS(16), .RESET_PC(16'h0000)) dut (
        .clock(clock),
        .reset(reset),
        .next_PC_select(next_PC_select),
        .target_PC(target_PC),
        .out_ready(out_ready),
        .PC(PC),
        .instruction(instruction),
        .out_valid(out_valid),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .fetch_fault(fetch_fault)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] word(input logic [15:0] a);
        return 32'hC0DE0000 | {16'h0000, a};
    endfunction

    // Memory answers `lat` cycles after the grant edge.
    initial begin
        m_addr = '0;
        forever begin
            @(posedge clock);
            m_g = imem_req && imem_gnt;
            m_a = imem_addr;
            #1;
            imem_rvalid = 1'b0;
            if (m_g) begin
                m_pend = lat;
                m_addr = m_a;
            end
            if (m_pend > 0) begin
                m_pend = m_pend - 1;
                if (m_pend == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word(m_addr);
                end
            end
        end
    end

    task automatic do_reset(input int l, input logic rdy);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        lat = l;
        out_ready = rdy;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        checks++; if (PC !== 16'h0) begin errors++; $display("FAIL rst_pc: got %h want 0000", PC); end
        checks++; if (instruction !== 32'h13) begin errors++; $display("FAIL rst_ins: got %h want 00000013", instruction); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rel_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 16'h0) begin errors++; $display("FAIL rel_addr: got %h want 0000", imem_addr); end
    endtask

    task automatic test_stream;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL st_n1_valid: got %b want 0", out_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_n1_req: got %b want 0", imem_req); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL st_first_valid: got %b want 1", out_valid); end
        checks++; if (PC !== 16'h0) begin errors++; $display("FAIL st_pc0: got %h want 0000", PC); end
        checks++; if (instruction !== word(16'h0)) begin errors++; $display("FAIL st_ins0: got %h want %h", instruction, word(16'h0)); end
        checks++; if (imem_addr !== 16'h4) begin errors++; $display("FAIL st_addr4: got %h want 0004", imem_addr); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL st_gap: got %b want 0", out_valid); end
        @(negedge clock);
        checks++; if (PC !== 16'h4 || out_valid !== 1'b1) begin errors++; $display("FAIL st_pc4: got %h/%b want 0004/1", PC, out_valid); end
        @(negedge clock);
        @(negedge clock);
        checks++; if (PC !== 16'h8 || out_valid !== 1'b1) begin errors++; $display("FAIL st_pc8: got %h/%b want 0008/1", PC, out_valid); end
        checks++; if (instruction !== word(16'h8)) begin errors++; $display("FAIL st_ins8: got %h want %h", instruction, word(16'h8)); end
    endtask

    task automatic test_backpressure;
        do_reset(1, 1'b0);
        repeat (4) @(negedge clock);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_n4_req: got %b want 0", imem_req); end
        repeat (2) @(negedge clock);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_n6_req: got %b want 0", imem_req); end
        checks++; if (PC !== 16'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_head: got %h/%b want 0000/1", PC, out_valid); end
        out_ready = 1'b1;
        @(negedge clock);
        checks++; if (PC !== 16'h4 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_pc4: got %h/%b want 0004/1", PC, out_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h8) begin errors++; $display("FAIL bp_resume: got %b/%h want 1/0008", imem_req, imem_addr); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", out_valid); end
        @(negedge clock);
        checks++; if (PC !== 16'h8 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_pc8: got %h/%b want 0008/1", PC, out_valid); end
    endtask

    task automatic test_redirect_wait;
        do_reset(2, 1'b1);
        @(negedge clock);
        next_PC_select = 1'b1;
        target_PC = 16'h0100;
        @(negedge clock);
        next_PC_select = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_drain_req: got %b want 0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_drain_valid: got %b want 0", out_valid); end
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("FAIL rw_req: got %b/%h want 1/0100", imem_req, imem_addr); end
        @(negedge clock);
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_stale: got %b want 0", out_valid); end
        @(negedge clock);
        checks++; if (PC !== 16'h0100 || out_valid !== 1'b1) begin errors++; $display("FAIL rw_pc: got %h/%b want 0100/1", PC, out_valid); end
        checks++; if (instruction !== word(16'h0100)) begin errors++; $display("FAIL rw_ins: got %h want %h", instruction, word(16'h0100)); end
    endtask

    task automatic test_redirect_rvalid;
        do_reset(1, 1'b1);
        @(negedge clock);
        next_PC_select = 1'b1;
        target_PC = 16'h0040;
        @(negedge clock);
        next_PC_select = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_push: got %b want 0", out_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL rr_req: got %b/%h want 1/0040", imem_req, imem_addr); end
        @(negedge clock);
        @(negedge clock);
        checks++; if (PC !== 16'h0040 || out_valid !== 1'b1) begin errors++; $display("FAIL rr_pc: got %h/%b want 0040/1", PC, out_valid); end
        next_PC_select = 1'b1;
        target_PC = 16'h0200;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rr_force: got %b want 0", imem_req); end
        @(negedge clock);
        next_PC_select = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_flush: got %b want 0", out_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200) begin errors++; $display("FAIL rr_req2: got %b/%h want 1/0200", imem_req, imem_addr); end
    endtask

    task automatic test_misalign;
        do_reset(1, 1'b1);
        repeat (2) @(negedge clock);
        next_PC_select = 1'b1;
        target_PC = 16'h0102;
        @(negedge clock);
        next_PC_select = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL ma_fault: got %b want 1", fetch_fault); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ma_valid: got %b want 0", out_valid); end
        repeat (3) @(negedge clock);
        checks++; if (imem_req !== 1'b0 || fetch_fault !== 1'b1) begin errors++; $display("FAIL ma_halt: got %b/%b want 0/1", imem_req, fetch_fault); end
`else
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL ma_fault: got %b want 0", fetch_fault); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("FAIL ma_addr: got %b/%h want 1/0100", imem_req, imem_addr); end
        repeat (2) @(negedge clock);
        checks++; if (PC !== 16'h0100 || out_valid !== 1'b1) begin errors++; $display("FAIL ma_pc: got %h/%b want 0100/1", PC, out_valid); end
`endif
    endtask

    task automatic test_midreset;
        do_reset(2, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mr_hold: got %b/%b want 0/0", imem_req, out_valid); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin errors++; $display("FAIL mr_req: got %b/%h want 1/0000", imem_req, imem_addr); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_stale: got %b want 0", out_valid); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_early: got %b want 0", out_valid); end
        @(negedge clock);
        checks++; if (PC !== 16'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL mr_pc: got %h/%b want 0000/1", PC, out_valid); end
        checks++; if (instruction !== word(16'h0)) begin errors++; $display("FAIL mr_ins: got %h want %h", instruction, word(16'h0)); end
    endtask

    initial begin
        reset = 1'b0;
        next_PC_select = 1'b0;
        target_PC = 16'h0;
        out_ready = 1'b1;
        imem_gnt = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect_wait;
        test_redirect_rvalid;
        test_misalign;
        test_midreset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
